// File: rtl/cd_tx_frame.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cd_tx_frame : feeds a buffered CDBUS frame byte-by-byte to the TX serializer
//               and appends the serializer's CRC. Handles retry/drop.
// Revision    : 1.0
// ----------------------------------------------------------------------------
module cd_tx_frame (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_valid,
  output logic [7:0]  rd_addr,
  input  logic [7:0]  rd_data,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy,
  input  logic [2:0]  retry_max,
  output logic [7:0]  data,
  output logic        has_data,
  input  logic        ack_data,
  output logic        is_crc_byte,
  output logic        is_last_byte,
  input  logic [15:0] crc_data,
  input  logic        cd,
  input  logic        err,
  input  logic        abort
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_CRC_L = 3'd3,
    S_CRC_H = 3'd4
  } state_t;

  localparam logic [7:0] c_LEN_MAX = 8'd253;

  state_t     state_q, state_d;
  logic       fetch_ph_q, fetch_ph_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] pf_q, pf_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] len_q, len_d;
  logic [2:0] retry_q, retry_d;
  logic       req_q, req_d;
  logic       cap_q, cap_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [7:0] w_pf;
  logic [7:0] w_last;
  logic [8:0] w_next_rd;
  logic       w_active;

  // RAM read issued by req_q returns on rd_data while cap_q is high
  assign w_pf      = cap_q ? rd_data : pf_q;
  assign w_last    = len_q + 8'd2;
  assign w_next_rd = {1'b0, idx_q} + 9'd2;
  assign w_active  = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      fetch_ph_q <= 1'b0;
      rd_addr_q  <= 8'd0;
      data_q     <= 8'd0;
      pf_q       <= 8'd0;
      idx_q      <= 8'd0;
      len_q      <= 8'd0;
      retry_q    <= 3'd0;
      req_q      <= 1'b0;
      cap_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_ph_q <= fetch_ph_d;
      rd_addr_q  <= rd_addr_d;
      data_q     <= data_d;
      pf_q       <= pf_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      retry_q    <= retry_d;
      req_q      <= req_d;
      cap_q      <= cap_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_ph_d = fetch_ph_q;
    rd_addr_d  = rd_addr_q;
    data_d     = data_q;
    pf_d       = pf_q;
    idx_d      = idx_q;
    len_d      = len_q;
    retry_d    = retry_q;
    req_d      = 1'b0;
    cap_d      = req_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (cap_q) begin
      pf_d = rd_data;
      if (rd_addr_q == 8'd2) begin
        len_d = (rd_data > c_LEN_MAX) ? c_LEN_MAX : rd_data;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (frame_valid) begin
          state_d    = S_FETCH;
          fetch_ph_d = 1'b0;
          retry_d    = 3'd0;
          rd_addr_d  = 8'd0;
          len_d      = 8'd0;
          cap_d      = 1'b0;
        end
      end
      S_FETCH: begin
        if (!fetch_ph_q) begin
          rd_addr_d  = 8'd1;
          req_d      = 1'b1;
          fetch_ph_d = 1'b1;
        end else begin
          data_d  = rd_data;
          idx_d   = 8'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (ack_data) begin
          if (idx_q < w_last) begin
            data_d = w_pf;
            idx_d  = idx_q + 8'd1;
            // Only refill while the next prefetch target is still inside the frame
            if (w_next_rd <= {1'b0, w_last}) begin
              rd_addr_d = w_next_rd[7:0];
              req_d     = 1'b1;
            end
          end else begin
            state_d = S_CRC_L;
          end
        end
      end
      S_CRC_L: begin
        if (ack_data) begin
          state_d = S_CRC_H;
        end
      end
      S_CRC_H: begin
        if (ack_data) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          rd_addr_d = 8'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Line events override the handshake: abort/err drop, cd rewinds or drops
    if (w_active) begin
      if (abort || err || (cd && (retry_q >= retry_max))) begin
        state_d   = S_IDLE;
        err_d     = 1'b1;
        done_d    = 1'b0;
        rd_addr_d = 8'd0;
        req_d     = 1'b0;
        cap_d     = 1'b0;
      end else if (cd) begin
        state_d    = S_FETCH;
        fetch_ph_d = 1'b0;
        retry_d    = retry_q + 3'd1;
        rd_addr_d  = 8'd0;
        req_d      = 1'b0;
        cap_d      = 1'b0;
      end
    end
  end

  always_comb begin
    data = 8'd0;
    case (state_q)
      S_SEND:  data = data_q;
      S_CRC_L: data = crc_data[7:0];
      S_CRC_H: data = crc_data[15:8];
      default: data = 8'd0;
    endcase
  end

  assign rd_addr      = rd_addr_q;
  assign has_data     = (state_q == S_SEND) || (state_q == S_CRC_L) || (state_q == S_CRC_H);
  assign is_crc_byte  = (state_q == S_CRC_L) || (state_q == S_CRC_H);
  assign is_last_byte = (state_q == S_CRC_H);
  assign busy         = w_active;
  assign frame_done   = done_q;
  assign frame_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cd_tx_frame.sv
`default_nettype none
// Testbench for cd_tx_frame: RAM model plus a serializer model that acks bytes
// and maintains a CRC-16 (poly 0xA001, init 0xFFFF) over the bytes it accepts.
module tb_cd_tx_frame;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_valid;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        frame_done;
  logic        frame_err;
  logic        busy;
  logic [2:0]  retry_max;
  logic [7:0]  data;
  logic        has_data;
  logic        ack_data;
  logic        is_crc_byte;
  logic        is_last_byte;
  logic [15:0] crc_data;
  logic        cd;
  logic        err;
  logic        abort;

  cd_tx_frame dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_valid  (frame_valid),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .busy         (busy),
    .retry_max    (retry_max),
    .data         (data),
    .has_data     (has_data),
    .ack_data     (ack_data),
    .is_crc_byte  (is_crc_byte),
    .is_last_byte (is_last_byte),
    .crc_data     (crc_data),
    .cd           (cd),
    .err          (err),
    .abort        (abort)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [256];
  always @(posedge clk) rd_data <= ram[rd_addr];

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] rx    [300];
  bit         crcf  [300];
  bit         lastf [300];
  int         rx_n, done_cnt, err_cnt, gap_err, max_addr;
  logic       hd_end, busy_end;
  logic [15:0] crc_r;
  int         inj_kind, inj_byte, inj_left;

  typedef struct {
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    int         gap;
    int         exp_n;
    int         exp_max;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  task automatic fill_ram(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 37 + 5);
    ram[0] = s;
    ram[1] = d;
    ram[2] = l;
  endtask

  task automatic launch();
    @(negedge clk);
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  // Serializer model; runs until a done/err pulse, a planted reset, or timeout
  task automatic serve(input int gap, input int maxcyc);
    int cnt, cyc;
    bit started, fin;
    cnt = 0; cyc = 0; started = 0; fin = 0;
    rx_n = 0; done_cnt = 0; err_cnt = 0; gap_err = 0; max_addr = 0;
    crc_r = 16'hFFFF;
    crc_data = crc_r;
    while (!fin && cyc < maxcyc) begin
      @(negedge clk);
      cyc++;
      ack_data = 1'b0; cd = 1'b0; abort = 1'b0;
      if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      if (frame_done || frame_err) begin
        done_cnt += int'(frame_done);
        err_cnt  += int'(frame_err);
        hd_end   = has_data;
        busy_end = busy;
        fin      = 1;
      end else if (inj_kind == 3 && inj_left > 0 && has_data && is_crc_byte && !is_last_byte) begin
        reset_n = 1'b0;
        inj_left--;
        fin = 1;
      end else begin
        if (started && !has_data) gap_err++;
        if (has_data) begin
          started = 1;
          cnt++;
          if (cnt >= gap) begin
            cnt = 0;
            if ((inj_kind == 1 || inj_kind == 2) && inj_left > 0 && rx_n == inj_byte && !is_crc_byte) begin
              inj_left--;
              if (inj_kind == 1) begin
                cd = 1'b1; rx_n = 0; crc_r = 16'hFFFF; started = 0;
              end else begin
                abort = 1'b1; ack_data = 1'b1;
              end
            end else begin
              ack_data = 1'b1;
              if (rx_n < 300) begin
                rx[rx_n] = data; crcf[rx_n] = is_crc_byte; lastf[rx_n] = is_last_byte;
                rx_n++;
              end
              if (!is_crc_byte) crc_r = crc_upd(crc_r, data);
            end
          end
        end
      end
      crc_data = crc_r;
    end
    chk("serve_terminated", 32'(fin), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int exp_n, input int exp_max);
    int bad, flag_bad;
    logic [15:0] ec, res;
    bad = 0; flag_bad = 0;
    ec = 16'hFFFF; res = 16'hFFFF;
    for (int i = 0; i < exp_n - 2; i++) begin
      ec = crc_upd(ec, ram[i]);
      if (i < rx_n && rx[i] !== ram[i]) bad++;
    end
    for (int i = 0; i < rx_n; i++) begin
      res = crc_upd(res, rx[i]);
      if (crcf[i] != (i >= rx_n - 2)) flag_bad++;
      if (lastf[i] != (i == rx_n - 1)) flag_bad++;
    end
    chk({tag, "_nbytes"}, 32'(rx_n), 32'(exp_n));
    chk({tag, "_bytes"}, 32'(bad), 32'd0);
    if (rx_n >= 2) begin
      chk({tag, "_crc_lo"}, {24'd0, rx[rx_n-2]}, {24'd0, ec[7:0]});
      chk({tag, "_crc_hi"}, {24'd0, rx[rx_n-1]}, {24'd0, ec[15:8]});
    end
    chk({tag, "_crc_residual"}, {16'd0, res}, 32'd0);
    chk({tag, "_flags"}, 32'(flag_bad), 32'd0);
    chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    chk({tag, "_err"}, 32'(err_cnt), 32'd0);
    chk({tag, "_has_data_gap"}, 32'(gap_err), 32'd0);
    chk({tag, "_end_hd_busy"}, {30'd0, hd_end, busy_end}, 32'd0);
    chk({tag, "_max_addr"}, 32'(max_addr), 32'(exp_max));
  endtask

  initial begin
    int pulses;
    reset_n = 1'b0; frame_valid = 1'b0; retry_max = 3'd2;
    ack_data = 1'b0; cd = 1'b0; err = 1'b0; abort = 1'b0; crc_data = 16'hFFFF;
    inj_kind = 0; inj_byte = 0; inj_left = 0;
    fill_ram(8'h01, 8'h02, 8'h00);

    vecs[0] = '{src: 8'h01, dst: 8'h02, len: 8'h00, gap: 10, exp_n: 5,   exp_max: 2};
    vecs[1] = '{src: 8'h10, dst: 8'h20, len: 8'h04, gap: 12, exp_n: 9,   exp_max: 6};
    vecs[2] = '{src: 8'hAA, dst: 8'h55, len: 8'hFD, gap: 10, exp_n: 258, exp_max: 255};
    vecs[3] = '{src: 8'h3C, dst: 8'hC3, len: 8'hFF, gap: 10, exp_n: 258, exp_max: 255};
    vecs[4] = '{src: 8'h00, dst: 8'hFF, len: 8'h01, gap: 15, exp_n: 6,   exp_max: 3};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {rd_addr, data, 6'd0, has_data, is_crc_byte, is_last_byte,
                          frame_done, frame_err, busy}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {rd_addr, data, 6'd0, has_data, is_crc_byte, is_last_byte,
                         frame_done, frame_err, busy}, 32'd0);

    // First-byte latency: frame_valid sampled at cycle 0, byte0 on data at cycle 3
    fill_ram(8'h01, 8'h02, 8'h00);
    @(negedge clk);
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    chk("c1_busy_addr_hd", {23'd0, busy, rd_addr, has_data}, {23'd0, 1'b1, 8'd0, 1'b0});
    @(negedge clk);
    chk("c2_has_data", 32'(has_data), 32'd0);
    @(negedge clk);
    chk("c3_first_byte", {23'd0, has_data, data}, {23'd0, 1'b1, 8'h01});
    serve(10, 4000);
    check_frame("len0", 5, 2);

    for (int v = 0; v < 5; v++) begin
      fill_ram(vecs[v].src, vecs[v].dst, vecs[v].len);
      launch();
      serve(vecs[v].gap, 6000);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_n, vecs[v].exp_max);
    end

    // One collision during byte 2, retries allowed
    fill_ram(8'h11, 8'h22, 8'h02);
    retry_max = 3'd2; inj_kind = 1; inj_byte = 2; inj_left = 1;
    launch();
    serve(10, 4000);
    check_frame("cd_retry", 7, 4);
    chk("cd_retry_used", 32'(inj_left), 32'd0);

    // Three collisions with retry_max=2: third one drops
    inj_kind = 1; inj_byte = 2; inj_left = 3;
    launch();
    serve(10, 4000);
    chk("cd3_err", 32'(err_cnt), 32'd1);
    chk("cd3_no_done", 32'(done_cnt), 32'd0);
    chk("cd3_end_hd_busy", {30'd0, hd_end, busy_end}, 32'd0);
    chk("cd3_injected", 32'(inj_left), 32'd0);

    // retry_max=0 drops on the first collision
    retry_max = 3'd0; inj_kind = 1; inj_byte = 1; inj_left = 3;
    launch();
    serve(10, 4000);
    chk("cd_rmax0_err", 32'(err_cnt), 32'd1);
    chk("cd_rmax0_one_cd", 32'(inj_left), 32'd2);
    retry_max = 3'd2;

    // Abort and ack in the same cycle mid-payload
    fill_ram(8'h10, 8'h20, 8'h04);
    inj_kind = 2; inj_byte = 4; inj_left = 1;
    launch();
    serve(10, 4000);
    chk("abort_err", 32'(err_cnt), 32'd1);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_end_hd_busy", {30'd0, hd_end, busy_end}, 32'd0);
    @(negedge clk);
    chk("abort_idle_outputs", {rd_addr, data, 6'd0, has_data, is_crc_byte, is_last_byte,
                               frame_done, frame_err, busy}, 32'd0);

    // Reset asserted while CRC_L is presented
    inj_kind = 3; inj_left = 1;
    launch();
    serve(10, 4000);
    chk("rst_mid_crc_seen", 32'(inj_left), 32'd0);
    #1;
    chk("rst_mid_crc_outputs", {rd_addr, data, 6'd0, has_data, is_crc_byte, is_last_byte,
                                frame_done, frame_err, busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) reset_n = 1'b1;
      pulses += int'(frame_done) + int'(frame_err);
    end
    chk("rst_mid_crc_no_pulse", 32'(pulses), 32'd0);
    chk("rst_mid_crc_idle", {31'd0, busy}, 32'd0);
    inj_kind = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
